if_id_reg: RTL and testbench

- Fetch/decode pipeline register. Sits directly downstream of the PC register and instruction memory.
- Captures the fetched PC and instruction each cycle and tags them with fetch-stage exception information: AdEL code and branch-delay flag.
- Presents these to the decode stage.
- Implements stall hold, exception-request bubble insertion and eret flush, so CP0 always sees a correct macroscopic PC.

---
 rtl/cpu_defs_pkg.sv | 22 ++
 rtl/fetch_addr_check.sv | 10 +
 rtl/if_id_reg.sv | 70 +++++++
 tb/tb_if_id_reg.sv | 116 +++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared CPU constants (ExcCodes, reset/handler PCs, instruction memory window)
// and the IF/ID pipeline slot type.
package cpu_defs;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } if_id_t;
endpackage

// File: rtl/fetch_addr_check.sv
// fetch_addr_check: flags a misaligned or out-of-window word address (AdEL/AdES source).
module fetch_addr_check #(
    parameter logic [31:0] IM_LO = cpu_defs::IM_LO,
    parameter logic [31:0] IM_HI = cpu_defs::IM_HI
) (
    input  logic [31:0] pc_i,
    output logic        bad_o
);
    assign bad_o = (pc_i[1:0] != 2'b00) || (pc_i < IM_LO) || (pc_i > IM_HI);
endmodule

// File: rtl/if_id_reg.sv
// if_id_reg: fetch/decode pipeline register with AdEL tagging, stall hold, Req bubble and eret flush.
// Optional stall cycle counter enabled by IF_ID_STALL_CNT_EN.
module if_id_reg #(
    parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
    parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC,
    parameter logic [31:0] IM_LO      = cpu_defs::IM_LO,
    parameter logic [31:0] IM_HI      = cpu_defs::IM_HI,
    parameter logic [4:0]  EXC_ADEL   = cpu_defs::EXC_ADEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_Instr,
    input  logic        D_isBJ,
    input  logic        stall,
    input  logic        Req,
    input  logic        D_eret,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD,
    output logic        D_valid,
    output logic [31:0] stall_cnt
);
    import cpu_defs::*;

    if_id_t slot_q, slot_d;
    logic   bad;

    fetch_addr_check #(.IM_LO(IM_LO), .IM_HI(IM_HI)) u_chk (
        .pc_i (F_PC),
        .bad_o(bad)
    );

    always_comb begin
        slot_d = slot_q;
        if (Req)
            slot_d = '{HANDLER_PC, 32'h0, EXC_INT, 1'b0, 1'b0};
        else if (stall)
            slot_d = slot_q;
        else if (D_eret)
            slot_d = '{F_PC, 32'h0, EXC_INT, 1'b0, 1'b0};
        else
            slot_d = '{F_PC, bad ? 32'h0 : F_Instr, bad ? EXC_ADEL : EXC_INT, D_isBJ, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) slot_q <= '{RESET_PC, 32'h0, EXC_INT, 1'b0, 1'b0};
        else       slot_q <= slot_d;
    end

    assign D_PC      = slot_q.pc;
    assign D_Instr   = slot_q.instr;
    assign D_ExcCode = slot_q.exc;
    assign D_BD      = slot_q.bd;
    assign D_valid   = slot_q.valid;

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    // Saturating: only Req-free stall cycles count.
    assign cnt_d = (!Req && stall && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 32'h0;
        else       cnt_q <= cnt_d;
    end
    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_if_id_reg.sv
// tb_if_id_reg: directed self-checking bench for if_id_reg.
module tb_if_id_reg;
    logic        clk = 1'b0;
    logic        reset, D_isBJ, stall, Req, D_eret;
    logic [31:0] F_PC, F_Instr;
    logic [31:0] D_PC, D_Instr, stall_cnt;
    logic [4:0]  D_ExcCode;
    logic        D_BD, D_valid;
    int n_tests = 0;
    int n_fail  = 0;

`ifdef IF_ID_STALL_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    if_id_reg dut (
        .clk(clk), .reset(reset), .F_PC(F_PC), .F_Instr(F_Instr), .D_isBJ(D_isBJ),
        .stall(stall), .Req(Req), .D_eret(D_eret), .D_PC(D_PC), .D_Instr(D_Instr),
        .D_ExcCode(D_ExcCode), .D_BD(D_BD), .D_valid(D_valid), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Req = 1'b0; stall = 1'b0; D_eret = 1'b0; D_isBJ = 1'b0;
        F_PC = 32'h0000_5000; F_Instr = 32'hDEAD_BEEF;
        step(); step();
        n_tests++; if (D_PC !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h want %h", D_PC, 32'h3000); end
        n_tests++; if (D_Instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", D_Instr); end
        n_tests++; if (D_valid !== 1'b0 || D_BD !== 1'b0 || D_ExcCode !== 5'd0) begin n_fail++; $display("FAIL reset_flags got v=%b bd=%b exc=%0d want 0/0/0", D_valid, D_BD, D_ExcCode); end
        n_tests++; if (stall_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", stall_cnt); end
    endtask

    task automatic test_capture();
        reset = 1'b0; F_PC = 32'h3000; F_Instr = 32'h3C01_0001;
        step();
        n_tests++; if (D_PC !== 32'h3000 || D_Instr !== 32'h3C01_0001) begin n_fail++; $display("FAIL capture got %h/%h want 00003000/3c010001", D_PC, D_Instr); end
        n_tests++; if (D_valid !== 1'b1 || D_ExcCode !== 5'd0) begin n_fail++; $display("FAIL capture_flags got v=%b exc=%0d want 1/0", D_valid, D_ExcCode); end
    endtask

    task automatic test_stall_req();
        F_PC = 32'h3004; F_Instr = 32'h0022_1820;
        step();
        stall = 1'b1; F_PC = 32'h3008; F_Instr = 32'h1234_5678;
        step(); step(); step();
        n_tests++; if (D_PC !== 32'h3004 || D_Instr !== 32'h0022_1820 || D_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold got %h/%h v=%b want 00003004/00221820 v=1", D_PC, D_Instr, D_valid); end
        n_tests++; if (stall_cnt !== (CNT_EN ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, CNT_EN ? 3 : 0); end
        Req = 1'b1;
        step();
        n_tests++; if (D_PC !== 32'h4180 || D_Instr !== 32'h0) begin n_fail++; $display("FAIL req_over_stall got %h/%h want 00004180/0", D_PC, D_Instr); end
        n_tests++; if (D_valid !== 1'b0 || D_BD !== 1'b0 || D_ExcCode !== 5'd0) begin n_fail++; $display("FAIL req_flags got v=%b bd=%b exc=%0d want 0/0/0", D_valid, D_BD, D_ExcCode); end
        n_tests++; if (stall_cnt !== (CNT_EN ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL req_cnt got %0d want %0d", stall_cnt, CNT_EN ? 3 : 0); end
        Req = 1'b0; stall = 1'b0;
    endtask

    task automatic test_adel();
        logic [31:0] pcs [4] = '{32'h3002, 32'h7000, 32'h6FFC, 32'h2FFC};
        logic [4:0]  exc [4] = '{5'd4, 5'd4, 5'd0, 5'd4};
        for (int i = 0; i < 4; i++) begin
            F_PC = pcs[i]; F_Instr = 32'hA5A5_0000 + 32'(i);
            step();
            n_tests++;
            if (D_ExcCode !== exc[i] || D_Instr !== (exc[i] != 0 ? 32'h0 : F_Instr) || D_PC !== pcs[i] || D_valid !== 1'b1) begin
                n_fail++; $display("FAIL adel_%h got exc=%0d instr=%h pc=%h v=%b want exc=%0d", pcs[i], D_ExcCode, D_Instr, D_PC, D_valid, exc[i]);
            end
        end
    endtask

    task automatic test_delay_slot();
        D_isBJ = 1'b1; F_PC = 32'h3010; F_Instr = 32'h0000_0000;
        step();
        n_tests++; if (D_BD !== 1'b1 || D_PC !== 32'h3010) begin n_fail++; $display("FAIL bd_set got bd=%b pc=%h want 1/00003010", D_BD, D_PC); end
        D_isBJ = 1'b0; F_PC = 32'h3014;
        step();
        n_tests++; if (D_BD !== 1'b0) begin n_fail++; $display("FAIL bd_clr got %b want 0", D_BD); end
    endtask

    task automatic test_eret();
        F_PC = 32'h3018; F_Instr = 32'h1111_2222;
        step();
        D_eret = 1'b1; stall = 1'b1; F_PC = 32'h3020; F_Instr = 32'h2402_0005;
        step();
        n_tests++; if (D_PC !== 32'h3018 || D_Instr !== 32'h1111_2222 || D_valid !== 1'b1) begin n_fail++; $display("FAIL eret_stall got %h/%h v=%b want 00003018/11112222 v=1", D_PC, D_Instr, D_valid); end
        stall = 1'b0;
        step();
        n_tests++; if (D_PC !== 32'h3020 || D_Instr !== 32'h0 || D_valid !== 1'b0 || D_ExcCode !== 5'd0) begin n_fail++; $display("FAIL eret_flush got %h/%h v=%b exc=%0d want 00003020/0 v=0 exc=0", D_PC, D_Instr, D_valid, D_ExcCode); end
        n_tests++; if (stall_cnt !== (CNT_EN ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL eret_cnt got %0d want %0d", stall_cnt, CNT_EN ? 4 : 0); end
        D_eret = 1'b0;
    endtask

    task automatic test_reset_priority();
        reset = 1'b1; Req = 1'b1; stall = 1'b1;
        step();
        n_tests++; if (D_PC !== 32'h3000 || D_valid !== 1'b0 || stall_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_wins got pc=%h v=%b cnt=%0d want 00003000/0/0", D_PC, D_valid, stall_cnt); end
        reset = 1'b0; Req = 1'b0; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_stall_req();
        test_adel();
        test_delay_slot();
        test_eret();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
